mem_responder: RTL and testbench

Memory-side responder for the north-bridge request interface. It sits below `mem_ctrl`, answers its `m_re`/`m_we` requests from an internal byte-wide RAM after a programmable fixed latency, and returns single-cycle `m_rack`/`m_wack` acknowledges. It serves as the main-memory model in simulation and as the on-chip RAM backend in FPGA builds.

---
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_responder.sv | 107 ++++++++++
 tb/tb_mem_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/acknowledge bus between mem_ctrl (master) and the memory responder (slave).
// Each request is a level; each acknowledge is a single-cycle pulse.
interface mem_responder_if #(
  parameter int M_DATA_L = 8,
  parameter int MADDR_L  = 32
);
  logic [M_DATA_L-1:0] m_wdata;
  logic [M_DATA_L-1:0] m_rdata;
  logic [MADDR_L-1:0]  m_raddr;
  logic [MADDR_L-1:0]  m_waddr;
  logic                m_re;
  logic                m_we;
  logic                m_rack;
  logic                m_wack;

  modport master (
    output m_wdata, m_raddr, m_waddr, m_re, m_we,
    input  m_rdata, m_rack, m_wack
  );

  modport slave (
    input  m_wdata, m_raddr, m_waddr, m_re, m_we,
    output m_rdata, m_rack, m_wack
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: serves one read or write at a time from an internal
// RAM and returns a one-cycle acknowledge LATENCY cycles after accepting the request.
module mem_responder #(
  parameter int M_DATA_L = 8,
  parameter int MADDR_L  = 32,
  parameter int DEPTH_L  = 10,
  parameter int LATENCY  = 3
) (
  input logic             clk,
  input logic             rst,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, ACK} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DEPTH_L-1:0]  addr_q, addr_d;
  logic [M_DATA_L-1:0] data_q, data_d;
  logic [M_DATA_L-1:0] rdata_q;
  logic                rack_q, rack_d;
  logic                wack_q, wack_d;
  logic                rd_load;
  logic                ram_we;

  logic [M_DATA_L-1:0] ram [2**DEPTH_L];

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rack_d  = 1'b0;
    wack_d  = 1'b0;
    rd_load = 1'b0;
    ram_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Write wins a tie; a still-pending read is picked up in a later IDLE cycle.
        if (bus.m_we) begin
          addr_d  = bus.m_waddr[DEPTH_L-1:0];
          data_d  = bus.m_wdata;
          cnt_d   = CNT_LOAD;
          state_d = WR_WAIT;
        end else if (bus.m_re) begin
          addr_d  = bus.m_raddr[DEPTH_L-1:0];
          cnt_d   = CNT_LOAD;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          rd_load = 1'b1;
          rack_d  = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          ram_we  = 1'b1;
          wack_d  = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      rack_q  <= 1'b0;
      wack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rack_q  <= rack_d;
      wack_q  <= wack_d;
      if (rd_load) rdata_q <= ram[addr_q];
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; reset only blocks the commit.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) ram[addr_q] <= data_q;
  end

  assign bus.m_rdata = rdata_q;
  assign bus.m_rack  = rack_q;
  assign bus.m_wack  = wack_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=3 and one at LATENCY=1,
// acting as a registered requester that drops its request once the acknowledge is seen.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if #(.M_DATA_L(8), .MADDR_L(32)) b3 ();
  mem_responder_if #(.M_DATA_L(8), .MADDR_L(32)) b1 ();

  mem_responder #(.M_DATA_L(8), .MADDR_L(32), .DEPTH_L(10), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .bus(b3.slave)
  );
  mem_responder #(.M_DATA_L(8), .MADDR_L(32), .DEPTH_L(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic get_ack(input bit which, input bit rd);
    if (which) return rd ? b1.m_rack : b1.m_wack;
    return rd ? b3.m_rack : b3.m_wack;
  endfunction

  function automatic logic [7:0] get_rdata(input bit which);
    return which ? b1.m_rdata : b3.m_rdata;
  endfunction

  task automatic drive(input bit which, input bit re, input bit we,
                       input logic [31:0] addr, input logic [7:0] data);
    if (which) begin
      b1.m_re = re; b1.m_we = we; b1.m_raddr = addr; b1.m_waddr = addr; b1.m_wdata = data;
    end else begin
      b3.m_re = re; b3.m_we = we; b3.m_raddr = addr; b3.m_waddr = addr; b3.m_wdata = data;
    end
  endtask

  // Counts rising edges until the acknowledge is seen; -1 on timeout.
  task automatic wait_ack(input bit which, input bit rd, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (get_ack(which, rd)) begin
        n = i;
        break;
      end
    end
  endtask

  // One full transaction; request driven #1 after an edge, so the next edge accepts it.
  task automatic xact(input bit which, input bit wr, input logic [31:0] addr,
                      input logic [7:0] data, input int lat, input string tag,
                      output int ack_cyc);
    int n;
    drive(which, !wr, wr, addr, data);
    wait_ack(which, !wr, n);
    drive(which, 1'b0, 1'b0, 32'h0, 8'h0);
    ack_cyc = cyc;
    check({tag, "_latency"}, n, lat + 1);
    check({tag, "_other_ack"}, get_ack(which, wr), 1'b0);
    @(posedge clk); #1;
    check({tag, "_ack_pulse"}, get_ack(which, !wr), 1'b0);
  endtask

  initial begin
    int n, t0, ta, tb;
    drive(1'b0, 1'b1, 1'b1, 32'h0, 8'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h0, 8'h0);

    // Reset held with both requests high: no acknowledges, rdata cleared.
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_rack3", b3.m_rack, 1'b0);
      check("rst_wack3", b3.m_wack, 1'b0);
      check("rst_rdata3", b3.m_rdata, 8'h00);
      check("rst_rack1", b1.m_rack, 1'b0);
      check("rst_wack1", b1.m_wack, 1'b0);
      check("rst_rdata1", b1.m_rdata, 8'h00);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 8'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write then read at LATENCY=3; rdata held across a later write.
    xact(1'b0, 1'b1, 32'h005, 8'hA5, 3, "wr5", t0);
    xact(1'b0, 1'b0, 32'h005, 8'h00, 3, "rd5", t0);
    check("rd5_data", get_rdata(1'b0), 8'hA5);
    xact(1'b0, 1'b1, 32'h006, 8'h5A, 3, "wr6", t0);
    check("rdata_hold_after_wr", get_rdata(1'b0), 8'hA5);

    // Simultaneous read and write: write first, read LATENCY+2 cycles after it.
    drive(1'b0, 1'b1, 1'b1, 32'h010, 8'h3C);
    wait_ack(1'b0, 1'b0, n);
    check("prio_wack_first", n, 4);
    check("prio_no_rack_yet", b3.m_rack, 1'b0);
    b3.m_we = 1'b0;
    wait_ack(1'b0, 1'b1, n);
    b3.m_re = 1'b0;
    check("prio_rack_gap", n, 5);
    check("prio_rdata", get_rdata(1'b0), 8'h3C);
    @(posedge clk); #1;

    // Upper address bits ignored: 0x400 aliases to 0x000.
    xact(1'b0, 1'b1, 32'h0000_0400, 8'h77, 3, "wrap_wr", t0);
    xact(1'b0, 1'b0, 32'h0000_0000, 8'h00, 3, "wrap_rd", t0);
    check("wrap_rdata", get_rdata(1'b0), 8'h77);

    // Reset during WR_WAIT drops the write and clears rdata.
    xact(1'b0, 1'b1, 32'h020, 8'h11, 3, "old_wr", t0);
    drive(1'b0, 1'b0, 1'b1, 32'h020, 8'hFF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_rdata", b3.m_rdata, 8'h00);
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_wack", b3.m_wack, 1'b0);
      @(posedge clk); #1;
    end
    xact(1'b0, 1'b0, 32'h020, 8'h00, 3, "midrst_rd", t0);
    check("midrst_rdata_old", get_rdata(1'b0), 8'h11);

    // LATENCY=1: back-to-back reads acknowledge exactly 3 cycles apart.
    xact(1'b1, 1'b1, 32'h001, 8'h12, 1, "l1_wr1", t0);
    xact(1'b1, 1'b1, 32'h002, 8'h34, 1, "l1_wr2", t0);
    xact(1'b1, 1'b0, 32'h001, 8'h00, 1, "l1_rd1", ta);
    check("l1_rd1_data", get_rdata(1'b1), 8'h12);
    xact(1'b1, 1'b0, 32'h002, 8'h00, 1, "l1_rd2", tb);
    check("l1_rd2_data", get_rdata(1'b1), 8'h34);
    check("l1_ack_spacing", tb - ta, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
